// File: rtl/retire_mon_pkg.sv
// retire_mon_pkg: shared types and constants for the retirement monitor.
//   trace_rec_t  - one trace FIFO record {pc, wr, dest, data}
//   mon_state_e  - monitor FSM states
//   error codes  - core error status values (NO_ERROR = 0) plus the
//                  monitor's own HALTED_ON_WATCHDOG code
package retire_mon_pkg;

  localparam logic [3:0] NO_ERROR               = 4'h0;
  localparam logic [3:0] HALTED_ON_MEMORY_ERROR = 4'h1;
  localparam logic [3:0] HALTED_ON_HALT         = 4'h2;
  localparam logic [3:0] HALTED_ON_ILLEGAL      = 4'h3;
  localparam logic [3:0] HALTED_ON_WATCHDOG     = 4'hF;

  typedef struct packed {
    logic [63:0] pc;
    logic        wr;
    logic [4:0]  dest;
    logic [63:0] data;
  } trace_rec_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } mon_state_e;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: circular trace buffer with a RETIRE_W-wide compacting push and
// a single-entry pop.
//   clk, rst   - clock, synchronous active-low reset (empties the buffer)
//   push_vld   - per-lane push request, lane 0 oldest
//   push_rec   - per-lane record
//   pop        - remove head entry (ignored when empty)
//   count      - entries held
//   free       - DEPTH - count
//   head_rec   - record at the head (valid when count != 0)
module trace_fifo
  import retire_mon_pkg::*;
#(
  parameter int unsigned RETIRE_W = 2,
  parameter int unsigned DEPTH    = 8,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic       [RETIRE_W-1:0]    push_vld,
  input  trace_rec_t [RETIRE_W-1:0]    push_rec,
  input  logic                         pop,
  output logic       [CW-1:0]          count,
  output logic       [CW-1:0]          free,
  output trace_rec_t                   head_rec
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  trace_rec_t              mem [DEPTH];
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [CW-1:0]           n_push;
  logic [RETIRE_W-1:0]     lane_wr;
  logic [PTR_W-1:0]        lane_addr [RETIRE_W];
  logic                    do_pop;

  assign free     = CW'(DEPTH) - count;
  assign do_pop   = pop && (count != '0);
  assign head_rec = mem[head];

  // Each valid lane takes the next consecutive slot after the valid lanes
  // below it; capacity is judged against count before this cycle's pop, so
  // once one lane misses, every later lane misses too.
  always_comb begin
    n_push = '0;
    for (int unsigned i = 0; i < RETIRE_W; i++) begin
      lane_addr[i] = tail + PTR_W'(n_push);
      lane_wr[i]   = push_vld[i] && (n_push < free);
      if (lane_wr[i]) n_push = n_push + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < RETIRE_W; i++) begin
      if (lane_wr[i]) mem[lane_addr[i]] <= push_rec[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_pop) head <= head + 1'b1;
      tail  <= tail + PTR_W'(n_push);
      count <= count + n_push - CW'(do_pop);
    end
  end

endmodule

// File: rtl/retire_trace_mon.sv
// retire_trace_mon: retirement monitor beside the ROB retire port.
//   clk, rst                  - clock, synchronous active-low reset
//   retire_*_i                - per-lane retire records, lane 0 oldest
//   error_status_i            - core error status (NO_ERROR = 0)
//   trace_vld_o / trace_rdy_i - trace FIFO pop handshake
//   trace_pc/wr/dest/data_o   - FIFO head record
//   stall_req_o               - free slots < RETIRE_W (previous cycle)
//   cycle_cnt_o, instr_cnt_o  - RUN cycle and retired instruction counters
//   halt_o, halt_code_o       - halted flag and captured halt reason
//   overflow_o                - sticky, set when lanes were dropped
module retire_trace_mon
  import retire_mon_pkg::*;
#(
  parameter int unsigned RETIRE_W   = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WDOG_CYC   = 4096,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RETIRE_W-1:0]      retire_vld_i,
  input  logic [RETIRE_W-1:0][63:0] retire_pc_i,
  input  logic [RETIRE_W-1:0]      retire_wr_en_i,
  input  logic [RETIRE_W-1:0][4:0] retire_dest_i,
  input  logic [RETIRE_W-1:0][63:0] retire_data_i,
  input  logic [3:0]               error_status_i,
  output logic                     trace_vld_o,
  input  logic                     trace_rdy_i,
  output logic [63:0]              trace_pc_o,
  output logic                     trace_wr_o,
  output logic [4:0]               trace_dest_o,
  output logic [63:0]              trace_data_o,
  output logic                     stall_req_o,
  output logic [CNT_W-1:0]         cycle_cnt_o,
  output logic [CNT_W-1:0]         instr_cnt_o,
  output logic                     halt_o,
  output logic [3:0]               halt_code_o,
  output logic                     overflow_o
);

  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WD_W = $clog2(WDOG_CYC + 1);

  mon_state_e                    state;
  logic       [WD_W-1:0]         wdog;
  logic       [RETIRE_W-1:0]     acc_vld;
  logic       [CW-1:0]           n_acc;
  logic       [CW-1:0]           fifo_count;
  logic       [CW-1:0]           fifo_free;
  trace_rec_t [RETIRE_W-1:0]     push_rec;
  trace_rec_t                    head_rec;
  logic                          wdog_hit;

  always_comb begin
    acc_vld = (state == RUN) ? retire_vld_i : '0;
    n_acc   = '0;
    for (int unsigned i = 0; i < RETIRE_W; i++) begin
      n_acc       = n_acc + CW'(acc_vld[i]);
      push_rec[i] = '{pc:   retire_pc_i[i],
                      wr:   retire_wr_en_i[i],
                      dest: retire_dest_i[i],
                      data: retire_data_i[i]};
    end
  end

  // Fires on the retire-free cycle that brings the idle count to WDOG_CYC.
  assign wdog_hit = (n_acc == '0) && (wdog == WD_W'(WDOG_CYC - 1));

  trace_fifo #(
    .RETIRE_W (RETIRE_W),
    .DEPTH    (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (acc_vld),
    .push_rec (push_rec),
    .pop      (trace_rdy_i),
    .count    (fifo_count),
    .free     (fifo_free),
    .head_rec (head_rec)
  );

  assign trace_vld_o  = (fifo_count != '0);
  assign trace_pc_o   = head_rec.pc;
  assign trace_wr_o   = head_rec.wr;
  assign trace_dest_o = head_rec.dest;
  assign trace_data_o = head_rec.data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      wdog        <= '0;
      cycle_cnt_o <= '0;
      instr_cnt_o <= '0;
      halt_o      <= 1'b0;
      halt_code_o <= NO_ERROR;
      overflow_o  <= 1'b0;
      stall_req_o <= 1'b0;
    end else begin
      stall_req_o <= (fifo_free < CW'(RETIRE_W));
      unique case (state)
        RUN: begin
          cycle_cnt_o <= cycle_cnt_o + 1'b1;
          instr_cnt_o <= instr_cnt_o + CNT_W'(n_acc);
          if (n_acc > fifo_free) overflow_o <= 1'b1;
          if (n_acc != '0) wdog <= '0;
          else             wdog <= wdog + 1'b1;
          if (error_status_i != NO_ERROR) begin
            halt_code_o <= error_status_i;
            state       <= DRAIN;
          end else if (wdog_hit) begin
            halt_code_o <= HALTED_ON_WATCHDOG;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_count == '0) begin
            state  <= HALTED;
            halt_o <= 1'b1;
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_retire_trace_mon.sv
// tb_retire_trace_mon: scoreboard bench for retire_trace_mon (RETIRE_W=2,
// FIFO_DEPTH=8, WDOG_CYC=16). Expected trace records are queued as retires
// are driven and compared as the DUT pops them; a small behavioural model
// supplies expected counters and status flags every cycle.
module tb_retire_trace_mon;
  import retire_mon_pkg::*;

  localparam int unsigned RW    = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned WDOG  = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [RW-1:0]        retire_vld_i;
  logic [RW-1:0][63:0]  retire_pc_i;
  logic [RW-1:0]        retire_wr_en_i;
  logic [RW-1:0][4:0]   retire_dest_i;
  logic [RW-1:0][63:0]  retire_data_i;
  logic [3:0]           error_status_i;
  logic                 trace_vld_o;
  logic                 trace_rdy_i;
  logic [63:0]          trace_pc_o;
  logic                 trace_wr_o;
  logic [4:0]           trace_dest_o;
  logic [63:0]          trace_data_o;
  logic                 stall_req_o;
  logic [31:0]          cycle_cnt_o;
  logic [31:0]          instr_cnt_o;
  logic                 halt_o;
  logic [3:0]           halt_code_o;
  logic                 overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  trace_rec_t  q [$];
  mon_state_e  m_state;
  int unsigned m_cyc, m_instr, m_wd;
  logic [3:0]  m_code;
  logic        m_halt, m_ovf, m_stall;

  retire_trace_mon #(
    .RETIRE_W   (RW),
    .FIFO_DEPTH (DEPTH),
    .WDOG_CYC   (WDOG),
    .CNT_W      (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .retire_vld_i   (retire_vld_i),
    .retire_pc_i    (retire_pc_i),
    .retire_wr_en_i (retire_wr_en_i),
    .retire_dest_i  (retire_dest_i),
    .retire_data_i  (retire_data_i),
    .error_status_i (error_status_i),
    .trace_vld_o    (trace_vld_o),
    .trace_rdy_i    (trace_rdy_i),
    .trace_pc_o     (trace_pc_o),
    .trace_wr_o     (trace_wr_o),
    .trace_dest_o   (trace_dest_o),
    .trace_data_o   (trace_data_o),
    .stall_req_o    (stall_req_o),
    .cycle_cnt_o    (cycle_cnt_o),
    .instr_cnt_o    (instr_cnt_o),
    .halt_o         (halt_o),
    .halt_code_o    (halt_code_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_lane(input int l, input logic [63:0] p);
    retire_pc_i[l]    = p;
    retire_wr_en_i[l] = ~p[2];
    retire_dest_i[l]  = p[6:2];
    retire_data_i[l]  = p ^ 64'hA5A5_0000_1234_0000;
  endtask

  task automatic do_reset();
    retire_vld_i   = '0;
    error_status_i = NO_ERROR;
    trace_rdy_i    = 1'b1;
    rst            = 1'b0;
    @(posedge clk); #1;
    rst     = 1'b1;
    q.delete();
    m_state = RUN;
    m_cyc   = 0;
    m_instr = 0;
    m_wd    = 0;
    m_code  = NO_ERROR;
    m_halt  = 1'b0;
    m_ovf   = 1'b0;
    m_stall = 1'b0;
  endtask

  // One clock: compare outputs at negedge, advance the model, return #1
  // after the next posedge so the caller can drive the following cycle.
  task automatic step();
    trace_rec_t r;
    int unsigned cnt0, n, cap, stored;
    @(negedge clk);
    check("trace_vld", trace_vld_o, q.size() != 0);
    check("stall", stall_req_o, m_stall);
    check("cycle_cnt", cycle_cnt_o, m_cyc);
    check("instr_cnt", instr_cnt_o, m_instr);
    check("halt", halt_o, m_halt);
    check("halt_code", halt_code_o, m_code);
    check("overflow", overflow_o, m_ovf);
    cnt0 = q.size();
    if (cnt0 != 0 && trace_rdy_i) begin
      r = q.pop_front();
      check("trace_pc", trace_pc_o, r.pc);
      check("trace_wr_dest", {trace_wr_o, trace_dest_o}, {r.wr, r.dest});
      check("trace_data", trace_data_o, r.data);
    end
    m_stall = (DEPTH - cnt0) < RW;
    case (m_state)
      RUN: begin
        n = 0;
        stored = 0;
        cap = DEPTH - cnt0;
        for (int l = 0; l < RW; l++) begin
          if (retire_vld_i[l]) begin
            n++;
            if (stored < cap) begin
              q.push_back('{pc: retire_pc_i[l], wr: retire_wr_en_i[l],
                            dest: retire_dest_i[l], data: retire_data_i[l]});
              stored++;
            end
          end
        end
        if (n > cap) m_ovf = 1'b1;
        m_instr += n;
        m_cyc++;
        if (n != 0) m_wd = 0;
        else        m_wd++;
        if (error_status_i != NO_ERROR) begin
          m_code  = error_status_i;
          m_state = DRAIN;
        end else if (m_wd == WDOG) begin
          m_code  = HALTED_ON_WATCHDOG;
          m_state = DRAIN;
        end
      end
      DRAIN: if (cnt0 == 0) begin
        m_state = HALTED;
        m_halt  = 1'b1;
      end
      default: ;
    endcase
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    retire_pc_i    = '0;
    retire_wr_en_i = '0;
    retire_dest_i  = '0;
    retire_data_i  = '0;
    do_reset();
    check("rst_trace_vld", trace_vld_o, 1'b0);
    check("rst_stall", stall_req_o, 1'b0);
    check("rst_cycle", cycle_cnt_o, 0);
    check("rst_instr", instr_cnt_o, 0);
    check("rst_halt", halt_o, 1'b0);
    check("rst_code", halt_code_o, 0);
    check("rst_ovf", overflow_o, 1'b0);

    // two lanes, in-order records
    drive_lane(0, 64'h100);
    drive_lane(1, 64'h104);
    retire_vld_i = 2'b11;
    step();
    check("a_vld_latency", trace_vld_o, 1'b1);
    retire_vld_i = '0;
    repeat (4) step();
    check("a_instr", instr_cnt_o, 2);
    check("a_empty", trace_vld_o, 1'b0);

    // lane 1 only: no gap
    do_reset();
    drive_lane(0, 64'hDEAD0);
    drive_lane(1, 64'h200);
    retire_vld_i = 2'b10;
    step();
    retire_vld_i = '0;
    check("b_head_pc", trace_pc_o, 64'h200);
    repeat (3) step();
    check("b_instr", instr_cnt_o, 1);

    // fill to 7, then overflow by one lane
    do_reset();
    trace_rdy_i = 1'b0;
    drive_lane(0, 64'h400);
    retire_vld_i = 2'b01;
    step();
    for (int k = 0; k < 4; k++) begin
      drive_lane(0, 64'h410 + 64'(k) * 64'h10);
      drive_lane(1, 64'h414 + 64'(k) * 64'h10);
      retire_vld_i = 2'b11;
      step();
      if (k == 2) check("c_stall_lag", stall_req_o, 1'b0);
    end
    check("c_stall", stall_req_o, 1'b1);
    check("c_ovf", overflow_o, 1'b1);
    check("c_instr", instr_cnt_o, 9);
    retire_vld_i = '0;
    trace_rdy_i  = 1'b1;
    repeat (9) step();
    check("c_drained", trace_vld_o, 1'b0);

    // halt on error with queued entries, halting pc last
    do_reset();
    trace_rdy_i = 1'b0;
    drive_lane(0, 64'h300);
    drive_lane(1, 64'h304);
    retire_vld_i = 2'b11;
    step();
    drive_lane(0, 64'h308);
    retire_vld_i   = 2'b01;
    error_status_i = HALTED_ON_HALT;
    step();
    error_status_i = NO_ERROR;
    trace_rdy_i    = 1'b1;
    drive_lane(0, 64'h500);
    drive_lane(1, 64'h504);
    retire_vld_i = 2'b11;
    step();
    retire_vld_i = '0;
    for (int k = 0; k < 20 && !halt_o; k++) step();
    check("d_halt", halt_o, 1'b1);
    check("d_code", halt_code_o, HALTED_ON_HALT);
    check("d_cycle_frozen", cycle_cnt_o, 2);
    check("d_instr_frozen", instr_cnt_o, 3);
    step();

    // minimum error-to-halt latency
    do_reset();
    error_status_i = HALTED_ON_ILLEGAL;
    step();
    error_status_i = NO_ERROR;
    check("e_halt_early", halt_o, 1'b0);
    step();
    check("e_halt_2cyc", halt_o, 1'b1);
    check("e_code", halt_code_o, HALTED_ON_ILLEGAL);

    // watchdog boundary
    do_reset();
    repeat (WDOG - 1) step();
    check("f_wdog_not_yet", halt_code_o, NO_ERROR);
    step();
    check("f_wdog_code", halt_code_o, HALTED_ON_WATCHDOG);
    repeat (2) step();
    check("f_wdog_halt", halt_o, 1'b1);

    // simultaneous error wins over watchdog
    do_reset();
    repeat (WDOG - 1) step();
    error_status_i = HALTED_ON_MEMORY_ERROR;
    step();
    error_status_i = NO_ERROR;
    check("g_prio_code", halt_code_o, HALTED_ON_MEMORY_ERROR);
    repeat (2) step();

    // reset while draining
    do_reset();
    trace_rdy_i = 1'b0;
    drive_lane(0, 64'h600);
    drive_lane(1, 64'h604);
    retire_vld_i   = 2'b11;
    error_status_i = HALTED_ON_ILLEGAL;
    step();
    retire_vld_i   = '0;
    error_status_i = NO_ERROR;
    step();
    check("h_in_drain_vld", trace_vld_o, 1'b1);
    do_reset();
    check("h_rst_vld", trace_vld_o, 1'b0);
    check("h_rst_code", halt_code_o, 0);
    check("h_rst_cycle", cycle_cnt_o, 0);
    check("h_rst_instr", instr_cnt_o, 0);
    check("h_rst_halt", halt_o, 1'b0);
    drive_lane(0, 64'h700);
    retire_vld_i = 2'b01;
    step();
    retire_vld_i = '0;
    check("h_run_after_rst", trace_pc_o, 64'h700);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
